// File: rtl/key_unexpand.sv
// AES-128 inverse key schedule: loads a final round key and streams round keys down to 0.
// Optional macro KEY_UNEXPAND_START_ROUND_EN adds a start_round input that picks the first round.
module key_unexpand #(
    parameter int unsigned LAST_ROUND = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            abort,
    input  logic [15:0][7:0] key_in,
`ifdef KEY_UNEXPAND_START_ROUND_EN
    input  logic [3:0]      start_round,
`endif
    input  logic            rk_ready,
    output logic            rk_valid,
    output logic [15:0][7:0] round_key,
    output logic [3:0]      round_idx,
    output logic            busy,
    output logic            done
);

    typedef enum logic {IDLE, EMIT} state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] rcon(input logic [3:0] k);
        case (k)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    state_t          state_q;
    logic [15:0][7:0] key_q;
    logic [3:0]      idx_q;
    logic            valid_q;
    logic            busy_q;
    logic            done_q;

    logic [3:0]      first_idx;
    logic [31:0]     w0, w1, w2, w3, w4, w5, w6, w7, rot_w, sub_w;
    logic [15:0][7:0] prev_key_d;

`ifdef KEY_UNEXPAND_START_ROUND_EN
    assign first_idx = (start_round > 4'd10) ? 4'd10 : start_round;
`else
    localparam logic [3:0] LAST_IDX = 4'(LAST_ROUND);
    assign first_idx = LAST_IDX;
`endif

    // Columns of the current round key are W4..W7; the step rebuilds W0..W3 of the round before.
    assign w4 = {key_q[15], key_q[11], key_q[7], key_q[3]};
    assign w5 = {key_q[14], key_q[10], key_q[6], key_q[2]};
    assign w6 = {key_q[13], key_q[9],  key_q[5], key_q[1]};
    assign w7 = {key_q[12], key_q[8],  key_q[4], key_q[0]};

    assign w3    = w7 ^ w6;
    assign w2    = w6 ^ w5;
    assign w1    = w5 ^ w4;
    assign rot_w = {w3[23:0], w3[31:24]};
    assign sub_w = {SBOX[rot_w[31:24]], SBOX[rot_w[23:16]], SBOX[rot_w[15:8]], SBOX[rot_w[7:0]]};
    assign w0    = w4 ^ sub_w ^ {rcon(idx_q), 24'h0};

    assign prev_key_d = {w0[31:24], w1[31:24], w2[31:24], w3[31:24],
                         w0[23:16], w1[23:16], w2[23:16], w3[23:16],
                         w0[15:8],  w1[15:8],  w2[15:8],  w3[15:8],
                         w0[7:0],   w1[7:0],   w2[7:0],   w3[7:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            key_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: done is a one-cycle pulse, so it defaults low and only the final handshake raises it.
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        state_q <= EMIT;
                        key_q   <= key_in;
                        idx_q   <= first_idx;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                EMIT: begin
                    if (abort) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (rk_ready) begin
                        if (idx_q == 4'd0) begin
                            state_q <= IDLE;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            key_q <= prev_key_d;
                            idx_q <= idx_q - 4'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rk_valid  = valid_q;
    assign round_key = key_q;
    assign round_idx = idx_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_key_unexpand.sv
// Bench for key_unexpand: expected round keys come from a forward FIPS-197 key expansion
// with an S-box derived from GF(2^8) arithmetic. Honours KEY_UNEXPAND_START_ROUND_EN.
module tb_key_unexpand;

    typedef logic [15:0][7:0] key_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       rk_ready = 1'b0;
    key_t       key_in = '0;
    logic       rk_valid, busy, done;
    key_t       round_key;
    logic [3:0] round_idx;
`ifdef KEY_UNEXPAND_START_ROUND_EN
    logic [3:0] start_round = '0;
`endif

    int errors = 0;
    int checks = 0;

    logic [7:0]  sbox_m [256];
    logic [31:0] sched [44];
    key_t        obs [11];

    localparam logic [127:0] A1_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    key_unexpand dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .key_in    (key_in),
`ifdef KEY_UNEXPAND_START_ROUND_EN
        .start_round(start_round),
`endif
        .rk_ready  (rk_ready),
        .rk_valid  (rk_valid),
        .round_key (round_key),
        .round_idx (round_idx),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = xtime(a);
            b = b >> 1;
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_m[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                            ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    // FIPS byte n lives at row n%4, column n/4, i.e. packed byte 15-(4*row+col).
    function automatic key_t fips2pk(input logic [127:0] f);
        key_t p;
        for (int n = 0; n < 16; n++)
            p[15 - (4 * (n % 4) + n / 4)] = f[127 - 8 * n -: 8];
        return p;
    endfunction

    task automatic expand(input logic [127:0] key);
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) sched[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = sched[i - 1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
                t[31:24] = t[31:24] ^ rc;
                rc = xtime(rc);
            end
            sched[i] = sched[i - 4] ^ t;
        end
    endtask

    function automatic key_t rk_of(input int r);
        return fips2pk({sched[4 * r], sched[4 * r + 1], sched[4 * r + 2], sched[4 * r + 3]});
    endfunction

    // mode 0: ready always high, 1: ready 1,0,0 repeating, 2: random ready plus spurious starts.
    task automatic run_stream(input int sr, input int mode, input int abort_at);
        int first, exp_idx, hs, vcyc;
        bit fin, aborted, rdy;
        first   = (sr > 10) ? 10 : sr;
        key_in  = rk_of(first);
        start   = 1'b1;
`ifdef KEY_UNEXPAND_START_ROUND_EN
        start_round = 4'(sr);
`endif
        @(posedge clk); #1;
        start = 1'b0;
        check("done_low_after_start", 128'(done), 128'(0));
        exp_idx = first; hs = 0; vcyc = 0; fin = 1'b0; aborted = 1'b0;
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            check("valid", 128'(rk_valid), 128'(1));
            check("busy", 128'(busy), 128'(1));
            check("idx", 128'(round_idx), 128'(exp_idx));
            check("key", round_key, rk_of(exp_idx));
            if (rk_valid) vcyc++;
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            rk_ready = rdy;
            start    = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            key_in   = {$urandom, $urandom, $urandom, $urandom};
            if (exp_idx == abort_at) abort = 1'b1;
            if (rdy && !abort) obs[exp_idx] = round_key;
            @(posedge clk); #1;
            if (abort) begin
                abort = 1'b0; start = 1'b0; rk_ready = 1'b0;
                aborted = 1'b1; fin = 1'b1;
                check("abort_valid", 128'(rk_valid), 128'(0));
                check("abort_busy", 128'(busy), 128'(0));
                check("abort_done", 128'(done), 128'(0));
                check("abort_key_kept", round_key, rk_of(abort_at));
            end else if (rdy) begin
                hs++;
                if (exp_idx == 0) fin = 1'b1;
                else exp_idx--;
            end
        end
        start = 1'b0; rk_ready = 1'b0;
        if (aborted) begin
            @(posedge clk); #1;
            check("abort_no_done", 128'(done), 128'(0));
            check("abort_idle", 128'(busy), 128'(0));
        end else begin
            check("run_finished", 128'(fin), 128'(1));
            check("done_pulse", 128'(done), 128'(1));
            check("end_valid", 128'(rk_valid), 128'(0));
            check("end_busy", 128'(busy), 128'(0));
            check("handshakes", 128'(hs), 128'(first + 1));
            if (mode == 0) check("valid_cycles", 128'(vcyc), 128'(first + 1));
        end
    endtask

    initial begin
        build_sbox();
        #1;
        check("rst_valid", 128'(rk_valid), 128'(0));
        check("rst_key", round_key, 128'(0));
        check("rst_idx", 128'(round_idx), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // FIPS-197 A.1 stream
        expand(A1_KEY);
        run_stream(10, 0, -1);
        check("a1_idx10", obs[10], fips2pk(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));
        check("a1_idx9", obs[9], fips2pk(128'hac7766f319fadc2128d12941575c006e));
        check("a1_idx1", obs[1], fips2pk(128'ha0fafe1788542cb123a339392a6c7605));
        check("a1_idx0", obs[0], fips2pk(A1_KEY));
        begin
            logic [31:0] top_bytes = {8'h2b, 8'h28, 8'hab, 8'h09};
            check("a1_idx0_bytes15_12", 128'(obs[0][15:12]), 128'(top_bytes));
        end

        // Zero key, started in the done cycle of the previous run
        expand(128'h0);
        run_stream(10, 0, -1);
        check("zero_idx10", obs[10], fips2pk(128'hb4ef5bcb3e92e21123e951cf6f8f188e));
        check("zero_idx1", obs[1], fips2pk(128'h62636363626363636263636362636363));
        check("zero_idx0", obs[0], 128'h0);

        // Backpressure, then abort at idx6
        expand(A1_KEY);
        run_stream(10, 1, -1);
        check("bp_idx0", obs[0], fips2pk(A1_KEY));
        run_stream(10, 0, 6);

        // start and abort together while idle
        start = 1'b1; abort = 1'b1; key_in = rk_of(10);
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        check("start_abort_valid", 128'(rk_valid), 128'(0));
        check("start_abort_busy", 128'(busy), 128'(0));

        // Asynchronous reset mid-run
        key_in = rk_of(10); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; rk_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_valid", 128'(rk_valid), 128'(0));
        check("mid_rst_key", round_key, 128'(0));
        check("mid_rst_idx", 128'(round_idx), 128'(0));
        check("mid_rst_busy", 128'(busy), 128'(0));
        check("mid_rst_done", 128'(done), 128'(0));
        @(posedge clk); #1;
        check("mid_rst_no_done", 128'(done), 128'(0));
        reset = 1'b0; rk_ready = 1'b0;
        run_stream(10, 0, -1);

        // Random cipher keys, mixed ready patterns and spurious starts
        for (int i = 0; i < 8; i++) begin
            expand({$urandom, $urandom, $urandom, $urandom});
            run_stream(10, i % 3, (i == 5) ? int'($urandom_range(0, 10)) : -1);
        end

`ifdef KEY_UNEXPAND_START_ROUND_EN
        expand(A1_KEY);
        run_stream(3, 0, -1);
        check("sr3_last", obs[0], fips2pk(A1_KEY));
        run_stream(0, 0, -1);
        check("sr0_key", obs[0], fips2pk(A1_KEY));
        run_stream(13, 1, -1);
        check("sr13_first", obs[10], fips2pk(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));
`endif

        @(posedge clk); #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/key_unexpand.md
Name: key_unexpand

Overview:
- AES-128 inverse key schedule; the reverse direction of the forward one-round keyexpand block.
- Takes the final round key (round 10, or `start_round` when the optional feature is built in).
- Steps backward one round per accepted beat and streams round keys 10..0 to the decryption datapath over a valid/ready interface.
- Lets decryption run on the fly without storing the full expanded schedule.

Parameters:
- LAST_ROUND, 10: round index of the key loaded on `start`. Legal range 1..10.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  load `key_in` and begin a run; honoured only when busy=0.
- abort  in  1  synchronous abort; return to IDLE next cycle, no `done`.
- key_in  in  [15:0][7:0]  round-LAST_ROUND key.
- rk_ready  in  1  consumer accepts `round_key` this cycle.
- rk_valid  out  1  `round_key` / `round_idx` valid.
- round_key  out  [15:0][7:0]  current round key.
- round_idx  out  4  round number of `round_key`.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse after the round-0 key is accepted.

Behaviour:
- Byte packing, identical to keyexpand:
  - byte [15-(4r+c)] holds matrix row r, column c.
  - FIPS byte n sits at row n%4, column n/4.
  - Word Wc = {[15-c],[11-c],[7-c],[3-c]}, first byte first.
- Reset (async): rk_valid=0, round_key=0, round_idx=0, busy=0, done=0, FSM=IDLE.
- FSM states IDLE, EMIT:
  - IDLE: start=1 → next cycle EMIT, round_key=key_in, round_idx=LAST_ROUND, rk_valid=1, busy=1.
  - EMIT, rk_valid & rk_ready with round_idx=k>0 → next cycle round_key=prev(k), round_idx=k-1, rk_valid stays 1.
  - EMIT, handshake with round_idx=0 → next cycle IDLE, rk_valid=0, busy=0, done=1 for exactly one cycle.
  - EMIT, rk_ready=0 → all outputs held stable.
- Latency and throughput:
  - 1 cycle from start to first valid key.
  - 1 key per cycle when rk_ready is held high.
  - Full run: LAST_ROUND+1 beats.
- Inverse step for key of round k, words W4..W7, producing round k-1 words W0..W3:
  - W3=W7^W6; W2=W6^W5; W1=W5^W4.
  - W0=W4^SubWord(RotWord(W3))^{Rcon[k],00,00,00}.
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
  - S-box must be bit-exact FIPS-197 (4 lookups, combinational).
  - Step result is registered; no combinational path from key_in to outputs.
- Boundary and simultaneous-event rules:
  - start while busy=1: ignored.
  - start and abort in the same cycle while IDLE: abort wins, stays IDLE.
  - abort in EMIT: next cycle IDLE, rk_valid=0, busy=0, done=0; round_key retains its last value.
  - start in the cycle done=1 (already IDLE): accepted normally.
  - Reset mid-run: immediate return to reset values; no done pulse.
  - round_idx never wraps below 0.

Optional Feature:
- Macro KEY_UNEXPAND_START_ROUND_EN.
- Defined:
  - adds input start_round[3:0], sampled with start.
  - the first key is tagged start_round and the run emits start_round..0.
  - start_round=0 emits a single beat then done.
  - start_round>10 is clamped to 10.
- Undefined: port absent; every run starts at LAST_ROUND.

Test Plan:
- Reset mid-run → all outputs 0 on the asynchronous assertion, no done pulse; a new start after reset works normally.
- FIPS-197 A.1 stream, rk_ready=1:
  - start with key_in=d014f9a8c9ee2589e13f0cc8b6630ca6 (FIPS order).
  - idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - idx9 = ac7766f319fadc2128d12941575c006e.
  - idx1 = a0fafe1788542cb123a339392a6c7605.
  - idx0 = 2b7e151628aed2a6abf7158809cf4f3c, bytes [15..12] = 2b,28,ab,09.
  - done one cycle after the idx0 beat; 11 consecutive valid cycles.
- Zero-key stream:
  - start with key_in=b4ef5bcb3e92e21123e951cf6f8f188e.
  - idx1 = 62636363626363636263636362636363.
  - idx0 = all zeros.
- Backpressure: drive rk_ready with pattern 1,0,0,1,… → key and idx hold while ready=0; no beat skipped or duplicated; exactly 11 handshakes.
- Abort and spurious start:
  - abort asserted at idx6 → IDLE next cycle, done=0.
  - start while busy → ignored, sequence unchanged.
- START_ROUND_EN build: start_round=3 with the A.1 round-3 key → 4 beats (idx3..0), last = 2b7e1516…; start_round=0 → 1 beat, then done.
